uart_field_bridge: RTL and testbench

- Parametrised Avalon-MM master that drives the on-chip RS-232 UART: polls status, assembles N received fixed-length fields, hands them to a compute core via start/finished, then streams the result back out.
- Key fields (first KEY_FIELDS) load once after reset; the data fields reload for every job.
- Generalises the earlier fixed 3x32-byte bridge to any field count/width and result length. Sits between the UART IP and any start/finished compute core (RSA, vision-score, etc.).

---
 rtl/uart_field_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_uart_field_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_field_bridge.sv
// Avalon-MM master that polls the RS-232 UART, gathers fixed-length fields,
// runs a start/finished core, then streams its result out. Option: CORE_TIMEOUT_EN.
module uart_field_bridge #(
    parameter int FIELD_BYTES    = 32,
    parameter int NUM_FIELDS     = 3,
    parameter int KEY_FIELDS     = 2,
    parameter int RESULT_BYTES   = 31,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                              avm_clk,
    input  logic                              avm_rst,
    output logic [4:0]                        avm_address,
    output logic                              avm_read,
    input  logic [31:0]                       avm_readdata,
    output logic                              avm_write,
    output logic [31:0]                       avm_writedata,
    input  logic                              avm_waitrequest,
    output logic [NUM_FIELDS*FIELD_BYTES*8-1:0] o_fields,
    output logic                              o_start,
    input  logic [FIELD_BYTES*8-1:0]          i_result,
    input  logic                              i_finished,
    output logic                              o_busy,
    output logic                              o_timeout
);
    localparam int FW = FIELD_BYTES * 8;
    localparam int IW = $clog2(NUM_FIELDS + 1);
    localparam int BW = $clog2(FIELD_BYTES + 1);
    localparam int TW = $clog2(RESULT_BYTES + 1);
    localparam int SH = (FIELD_BYTES - RESULT_BYTES) * 8;
    localparam logic [4:0] A_RX = 5'd0;
    localparam logic [4:0] A_TX = 5'd4;
    localparam logic [4:0] A_ST = 5'd8;

    typedef enum logic [2:0] {
        POLL_RX, READ_RX, START, WAIT_CORE, POLL_TX, WRITE_TX
    } state_t;

    state_t                   state, state_d;
    logic [IW-1:0]            field_idx, field_idx_d, fsel;
    logic [BW-1:0]            byte_cnt, byte_cnt_d;
    logic [TW-1:0]            tx_cnt, tx_cnt_d;
    logic [FW-1:0]            tx_sr, tx_sr_d, cur_field;
    logic [NUM_FIELDS*FW-1:0] fields_d;
    logic                     rd_ok, wr_ok, expired;
    logic                     read_d, write_d, start_d, busy_d;
    logic [4:0]               addr_d;
    logic [31:0]              wdata_d;
    logic                     unused_rdata;

    assign rd_ok = avm_read && !avm_waitrequest;
    assign wr_ok = avm_write && !avm_waitrequest;
    assign unused_rdata = ^{avm_readdata[31:8], avm_readdata[5:0]};

`ifdef CORE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst)
            wd_cnt <= '0;
        else if (state != WAIT_CORE)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign expired = (state == WAIT_CORE) && !i_finished &&
                     (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign expired = 1'b0;
`endif

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state         <= POLL_RX;
            field_idx     <= '0;
            byte_cnt      <= '0;
            tx_cnt        <= '0;
            tx_sr         <= '0;
            o_fields      <= '0;
            avm_read      <= 1'b1;
            avm_address   <= A_ST;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            o_start       <= 1'b0;
            o_busy        <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            state         <= state_d;
            field_idx     <= field_idx_d;
            byte_cnt      <= byte_cnt_d;
            tx_cnt        <= tx_cnt_d;
            tx_sr         <= tx_sr_d;
            o_fields      <= fields_d;
            avm_read      <= read_d;
            avm_address   <= addr_d;
            avm_write     <= write_d;
            avm_writedata <= wdata_d;
            o_start       <= start_d;
            o_busy        <= busy_d;
            o_timeout     <= expired;
        end
    end

    // field_idx sits at NUM_FIELDS while the core runs; keep the slice in range
    assign fsel = (field_idx < IW'(NUM_FIELDS)) ? field_idx : '0;
    assign cur_field = o_fields[int'(fsel)*FW +: FW];

    always_comb begin
        state_d     = state;
        field_idx_d = field_idx;
        byte_cnt_d  = byte_cnt;
        tx_cnt_d    = tx_cnt;
        tx_sr_d     = tx_sr;
        fields_d    = o_fields;
        unique case (state)
            POLL_RX: begin
                if (rd_ok && avm_readdata[7])
                    state_d = READ_RX;
            end
            READ_RX: begin
                if (rd_ok) begin
                    fields_d[int'(fsel)*FW +: FW] =
                        (cur_field << 8) | FW'(avm_readdata[7:0]);
                    state_d = POLL_RX;
                    if (byte_cnt == BW'(FIELD_BYTES - 1)) begin
                        byte_cnt_d  = '0;
                        field_idx_d = field_idx + 1'b1;
                        if (field_idx == IW'(NUM_FIELDS - 1))
                            state_d = START;
                    end else begin
                        byte_cnt_d = byte_cnt + 1'b1;
                    end
                end
            end
            START: state_d = WAIT_CORE;
            WAIT_CORE: begin
                if (i_finished) begin
                    tx_sr_d  = i_result << SH;
                    tx_cnt_d = '0;
                    state_d  = POLL_TX;
                end else if (expired) begin
                    tx_sr_d  = '1;
                    tx_cnt_d = '0;
                    state_d  = POLL_TX;
                end
            end
            POLL_TX: begin
                if (rd_ok && avm_readdata[6])
                    state_d = WRITE_TX;
            end
            WRITE_TX: begin
                if (wr_ok) begin
                    tx_cnt_d = tx_cnt + 1'b1;
                    tx_sr_d  = tx_sr << 8;
                    if (tx_cnt == TW'(RESULT_BYTES - 1)) begin
                        field_idx_d = IW'(KEY_FIELDS);
                        byte_cnt_d  = '0;
                        state_d     = POLL_RX;
                    end else begin
                        state_d = POLL_TX;
                    end
                end
            end
            default: state_d = POLL_RX;
        endcase
    end

    // Bus strobes for the next cycle; a received byte leaves one idle cycle
    always_comb begin
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = A_ST;
        wdata_d = avm_writedata;
        start_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_d)
            POLL_RX: read_d = (state != READ_RX);
            READ_RX: begin
                read_d = 1'b1;
                addr_d = A_RX;
            end
            START: begin
                start_d = 1'b1;
                busy_d  = 1'b1;
            end
            WAIT_CORE: busy_d = 1'b1;
            POLL_TX: begin
                read_d = 1'b1;
                busy_d = 1'b1;
            end
            WRITE_TX: begin
                write_d = 1'b1;
                addr_d  = A_TX;
                busy_d  = 1'b1;
                wdata_d = {24'h0, tx_sr_d[FW-1 -: 8]};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_field_bridge.sv
// Bench for uart_field_bridge: UART slave model with stalls, field/TX scoreboard.
// Timeout job runs only when CORE_TIMEOUT_EN is defined.
module tb_uart_field_bridge;
    localparam int FB = 4;
    localparam int NF = 3;
    localparam int KF = 2;
    localparam int RB = 3;
    localparam int TO = 50;

    logic          avm_clk = 1'b0;
    logic          avm_rst = 1'b1;
    logic [4:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest;
    logic [95:0]   o_fields;
    logic          o_start;
    logic [31:0]   i_result = '0;
    logic          i_finished = 1'b0;
    logic          o_busy;
    logic          o_timeout;

    uart_field_bridge #(
        .FIELD_BYTES(FB), .NUM_FIELDS(NF), .KEY_FIELDS(KF),
        .RESULT_BYTES(RB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_fields(o_fields), .o_start(o_start),
        .i_result(i_result), .i_finished(i_finished),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 avm_clk = ~avm_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Host/UART side state
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    int          jobq[$];
    logic [31:0] exp_f[NF];
    bit          rx_acc = 0, wr_acc = 0, rx_granted = 0;
    bit          tx_ok = 0, in_xfer = 0, slow = 0, to_mode = 0;
    logic [7:0]  wr_byte = '0;
    int          stall_left = 0, sidx = 0;
    int          stalls[8] = '{0, 2, 1, 3, 0, 1, 0, 2};

    function automatic logic [95:0] exp_packed();
        return {exp_f[2], exp_f[1], exp_f[0]};
    endfunction

    // UART slave: while stalled, status claims RX_OK/TX_OK and RX shows junk
    initial begin
        bit ok;
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        forever begin
            @(negedge avm_clk);
            rx_acc = 0;
            wr_acc = 0;
            if (avm_rst || !(avm_read || avm_write)) begin
                in_xfer = 0;
                avm_waitrequest = 1'b0;
                avm_readdata = '0;
                if (avm_rst) rx_granted = 0;
            end else begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    stall_left = slow ? 5 : stalls[sidx];
                    sidx = (sidx + 1) % 8;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    avm_waitrequest = 1'b1;
                    avm_readdata = (avm_address == 5'd8) ? 32'hC0 : 32'hEE;
                end else begin
                    in_xfer = 0;
                    avm_waitrequest = 1'b0;
                    if (avm_write) begin
                        wr_acc = 1;
                        wr_byte = avm_writedata[7:0];
                    end else if (avm_address == 5'd8) begin
                        ok = rx_q.size() > 0;
                        avm_readdata = {24'h0, ok, tx_ok, 6'h0};
                        if (ok) rx_granted = 1;
                        tx_ok = !tx_ok;
                    end else begin
                        chk("rx_byte_available", rx_q.size() > 0, 1);
                        rx_acc = 1;
                        rx_granted = 0;
                        avm_readdata = (rx_q.size() > 0) ?
                                       {24'h0, rx_q.pop_front()} : 32'hEE;
                    end
                end
            end
        end
    end

    // Compare process: runs 1 time unit after every rising edge
    initial begin
        int  left = 0, n_tx = 0, since = 0;
        bit  started = 0, exp_start, exp_busy, exp_to;
        forever begin
            @(posedge avm_clk);
            #1;
            if (!avm_rst) begin
                exp_start = 0;
                if (rx_acc) begin
                    if (left == 0 && jobq.size() > 0) left = jobq.pop_front();
                    if (left > 0) begin
                        left--;
                        exp_start = (left == 0);
                    end
                end
                chk("o_start", o_start, exp_start);
                if (exp_start) begin
                    started = 1;
                    n_tx = 0;
                    since = 0;
                end else if (since < 100000) begin
                    since++;
                end
                if (wr_acc) begin
                    chk("tx_expected", exp_tx.size() > 0, 1);
                    if (exp_tx.size() > 0) chk("tx_byte", wr_byte, exp_tx.pop_front());
                    tx_log.push_back(wr_byte);
                    n_tx++;
                end
                exp_busy = started && (n_tx < RB);
                if (started && n_tx >= RB) started = 0;
                chk("o_busy", o_busy, exp_busy);
                if (o_start || o_busy) chk("o_fields", o_fields, exp_packed());
                chk("rd_wr_exclusive", avm_read && avm_write, 0);
                if (avm_read && avm_address == 5'd0)
                    chk("rx_read_after_rx_ok", rx_granted, 1);
                exp_to = to_mode && started && (since == TO + 1);
                chk("o_timeout", o_timeout, exp_to);
            end
        end
    end

    task automatic run_job(input logic [95:0] data, input int n, input int base,
                           input logic [31:0] res, input bit tmode,
                           input logic [95:0] f_lit, input logic [23:0] tx_lit);
        int k;
        int idx;
        int pos;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = data[(n-1-i)*8 +: 8];
            idx = base + i / FB;
            pos = FB - 1 - (i % FB);
            exp_f[idx][pos*8 +: 8] = b;
            rx_q.push_back(b);
        end
        jobq.push_back(n);
        tx_log.delete();
        k = 0;
        while (!o_start && k < 3000) begin
            @(negedge avm_clk);
            k++;
        end
        chk("start_seen", o_start, 1);
        chk("fields_literal", o_fields, f_lit);
        for (int i = 0; i < RB; i++)
            exp_tx.push_back(tmode ? 8'hFF : res[(RB-1-i)*8 +: 8]);
        // pulse during the START cycle must be ignored
        i_finished = 1'b1;
        i_result = 32'hDEADBEEF;
        @(negedge avm_clk);
        i_finished = 1'b0;
        if (tmode) begin
            k = 0;
            while (!o_timeout && k < 200) begin
                @(negedge avm_clk);
                k++;
            end
            chk("timeout_seen", o_timeout, 1);
        end else begin
            repeat (3) @(negedge avm_clk);
        end
        i_finished = 1'b1;
        i_result = res;
        @(negedge avm_clk);
        i_finished = 1'b0;
        k = 0;
        while ((o_busy || exp_tx.size() != 0) && k < 3000) begin
            @(negedge avm_clk);
            k++;
        end
        chk("job_done", o_busy || exp_tx.size() != 0, 0);
        chk("tx_literal", {tx_log[0], tx_log[1], tx_log[2]}, tx_lit);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NF; i++) exp_f[i] = '0;
        repeat (3) @(negedge avm_clk);
        chk("rst_read", avm_read, 1);
        chk("rst_addr", avm_address, 8);
        chk("rst_write", avm_write, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_fields", o_fields, 0);
        chk("rst_flags", {o_start, o_busy, o_timeout}, 0);
        avm_rst = 1'b0;
        repeat (4) @(negedge avm_clk);
        chk("idle_read", avm_read, 1);
        chk("idle_fields", o_fields, 0);

        run_job(96'h0102030405060708090A0B0C, 12, 0, 32'hAABBCCDD, 0,
                96'h090A0B0C_05060708_01020304, 24'hBBCCDD);
        slow = 1;
        run_job(96'h11223344, 4, KF, 32'h01020304, 0,
                96'h11223344_05060708_01020304, 24'h020304);
        slow = 0;
        run_job(96'hA1B2C3D4, 4, KF, 32'h99887766, 0,
                96'hA1B2C3D4_05060708_01020304, 24'h887766);
`ifdef CORE_TIMEOUT_EN
        to_mode = 1;
        run_job(96'h55667788, 4, KF, 32'h12345678, 1,
                96'h55667788_05060708_01020304, 24'hFFFFFF);
        to_mode = 0;
`endif

        // reset in the middle of a first job discards keys and partial data
        for (int i = 0; i < 5; i++) rx_q.push_back(8'hE0 + 8'(i));
        repeat (15) @(negedge avm_clk);
        avm_rst = 1'b1;
        rx_q.delete();
        jobq.delete();
        for (int i = 0; i < NF; i++) exp_f[i] = '0;
        repeat (2) @(negedge avm_clk);
        chk("midrst_fields", o_fields, 0);
        chk("midrst_read", avm_read, 1);
        avm_rst = 1'b0;
        @(negedge avm_clk);
        run_job(96'h2122232425262728292A2B2C, 12, 0, 32'h00C0FFEE, 0,
                96'h292A2B2C_25262728_21222324, 24'hC0FFEE);

        repeat (5) @(negedge avm_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
